lcd_cmd_sched: RTL

Two-requester command scheduler in front of the LCD_CTRL datapath. It buffers commands from two independent requesters in per-requester FIFOs and arbitrates between them. It issues each command to LCD_CTRL under the busy handshake, streams the 64-byte image from the granted requester's image bank for LOAD commands, and tags LCD output bytes with the owning requester.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_cmd_fifo.sv | 51 +++++
 rtl/lcd_cmd_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: command codes, image size and FSM states.
package lcd_pkg;

    localparam int IMG_N = 64;

    localparam logic [2:0] CMD_WRITE   = 3'h0;
    localparam logic [2:0] CMD_LOAD    = 3'h1;
    localparam logic [2:0] CMD_SHIFT_R = 3'h2;
    localparam logic [2:0] CMD_SHIFT_L = 3'h3;
    localparam logic [2:0] CMD_SHIFT_U = 3'h4;
    localparam logic [2:0] CMD_SHIFT_D = 3'h5;
    localparam logic [2:0] CMD_AVERAGE = 3'h6;
    localparam logic [2:0] CMD_MIRROR  = 3'h7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_GUARD,
        ST_WAIT
    } sched_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO with full/empty flags; head entry is visible combinationally.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Two-requester command scheduler in front of LCD_CTRL with image streaming and output tagging.
// Define LCD_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 first) instead of round-robin.
//
// state | meaning
// IDLE  | wait for a queued command and lcd_busy low, then grant and pop
// ISSUE | one-cycle cmd strobe; LOAD also reads image index 0
// LOAD  | read image indices 1..IMG_N-1, busy ignored
// GUARD | one cycle for LCD_CTRL to raise busy
// WAIT  | hold until lcd_busy falls
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_cmd_0,
    input  logic       req_valid_0,
    output logic       req_ready_0,
    input  logic [2:0] req_cmd_1,
    input  logic       req_valid_1,
    output logic       req_ready_1,
    output logic       img_rd,
    output logic [6:0] img_addr,
    input  logic [7:0] img_rdata,
    output logic [2:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic [7:0] lcd_datain,
    input  logic       lcd_busy,
    input  logic [7:0] lcd_dataout,
    input  logic       lcd_output_valid,
    output logic [7:0] out_data,
    output logic       out_valid_0,
    output logic       out_valid_1
);
    localparam int IDX_W = $clog2(IMG_N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_N - 1);

    sched_state_e     state_q, state_d;
    logic             owner_q, owner_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rd_q;
`ifndef LCD_SCHED_FIXED_PRIO_EN
    logic             last_q, last_d;
`endif

    logic [2:0] head_0, head_1;
    logic       full_0, full_1, empty_0, empty_1;
    logic       pop_0, pop_1;
    logic       win;

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(3)) u_fifo_0 (
        .clk     (clk),
        .reset   (reset),
        .push_i  (req_valid_0),
        .pop_i   (pop_0),
        .din_i   (req_cmd_0),
        .head_o  (head_0),
        .full_o  (full_0),
        .empty_o (empty_0)
    );

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(3)) u_fifo_1 (
        .clk     (clk),
        .reset   (reset),
        .push_i  (req_valid_1),
        .pop_i   (pop_1),
        .din_i   (req_cmd_1),
        .head_o  (head_1),
        .full_o  (full_1),
        .empty_o (empty_1)
    );

    assign req_ready_0 = !full_0;
    assign req_ready_1 = !full_1;

`ifdef LCD_SCHED_FIXED_PRIO_EN
    assign win = empty_0;
`else
    assign win = (!empty_0 && !empty_1) ? !last_q : empty_0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cmd_q   <= '0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
`ifndef LCD_SCHED_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            rd_q    <= img_rd;
`ifndef LCD_SCHED_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cmd_d         = cmd_q;
        idx_d         = idx_q;
`ifndef LCD_SCHED_FIXED_PRIO_EN
        last_d        = last_q;
`endif
        pop_0         = 1'b0;
        pop_1         = 1'b0;
        lcd_cmd_valid = 1'b0;
        img_rd        = 1'b0;
        img_addr      = '0;
        case (state_q)
            ST_IDLE: begin
                if ((!empty_0 || !empty_1) && !lcd_busy) begin
                    owner_d = win;
                    cmd_d   = win ? head_1 : head_0;
                    pop_0   = !win;
                    pop_1   = win;
`ifndef LCD_SCHED_FIXED_PRIO_EN
                    last_d  = win;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lcd_cmd_valid = 1'b1;
                if (cmd_q == CMD_LOAD) begin
                    img_rd   = 1'b1;
                    img_addr = {owner_q, {IDX_W{1'b0}}};
                    idx_d    = IDX_W'(1);
                    state_d  = ST_LOAD;
                end else begin
                    state_d  = ST_GUARD;
                end
            end
            ST_LOAD: begin
                img_rd   = 1'b1;
                img_addr = {owner_q, idx_q};
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = ST_GUARD;
            end
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!lcd_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Image bytes arrive one cycle after each read, so the stream window is the delayed read strobe.
    assign lcd_cmd     = cmd_q;
    assign lcd_datain  = rd_q ? img_rdata : 8'h00;
    assign out_data    = lcd_dataout;
    assign out_valid_0 = lcd_output_valid && !owner_q;
    assign out_valid_1 = lcd_output_valid && owner_q;

endmodule
